zero_pad_framer: RTL and testbench
==================================

ZERO_PAD_FRAMER -- requirements
Module: zero_pad_framer

Interface
REQ-001 SHALL have parameter IMAGE_HEIGHT, default 200, meaning padded frame rows.
REQ-002 SHALL have parameter IMAGE_WIDTH, default 200, meaning padded frame columns.
REQ-003 SHALL have parameter KERNEL_WIDTH, default 3, meaning convolver kernel side; PAD = (KERNEL_WIDTH-1)/2.
REQ-004 SHALL have parameter DATA_WIDTH, default 32, meaning beat width, with one beat per pixel position.
REQ-005 SHALL have port axi_clk, input, 1, meaning the single clock.
REQ-006 SHALL have port axi_reset, input, 1, meaning the reset, which is asynchronous and active-high.
REQ-007 SHALL have ports s_axis_valid/s_axis_ready/s_axis_last (1b each) and s_axis_data (DATA_WIDTH), forming the unpadded raster input stream.
REQ-008 SHALL have ports m_axis_valid/m_axis_ready/m_axis_last/m_axis_user (1b each) and m_axis_data (DATA_WIDTH), forming the padded stream to the convolver; m_axis_user marks the first beat of the frame.
REQ-009 SHALL have output o_frame_err, 1, meaning a one-cycle pulse on input tlast misalignment.

Function
REQ-010 SHALL emit IMAGE_HEIGHT*IMAGE_WIDTH beats per frame in row-major order, using row counter r and column counter c.
REQ-011 SHALL treat a position as border when r<PAD, r>=IMAGE_HEIGHT-PAD, c<PAD, or c>=IMAGE_WIDTH-PAD; border beats carry data 0 and consume no input.
REQ-012 SHALL pass the next input beat's data unchanged at interior positions, consuming exactly one input beat per interior position.
REQ-013 SHALL implement FSM IDLE -> ACTIVE when s_axis_valid=1; ACTIVE -> IDLE after the output handshake of beat (IMAGE_HEIGHT-1, IMAGE_WIDTH-1).
REQ-014 SHALL drive s_axis_ready = 1 only in ACTIVE, at an interior position, with the output register free (!m_axis_valid || m_axis_ready).
REQ-015 SHALL register outputs: the output register loads when free and (border, or interior with s_axis_valid); otherwise it holds data/valid/last/user stable while m_axis_valid=1 and m_axis_ready=0.
REQ-016 SHALL sustain one beat per cycle with m_axis_ready=1 and continuous input; latency from input handshake to m_axis_valid SHALL be 1 cycle.
REQ-017 SHALL advance r/c on each output-register load; c wraps at IMAGE_WIDTH-1 to 0 and increments r; r wraps at IMAGE_HEIGHT-1 to 0.
REQ-018 SHALL set m_axis_last only on beat (IMAGE_HEIGHT-1, IMAGE_WIDTH-1) and m_axis_user only on beat (0,0).
REQ-019 SHALL insert border beats while in ACTIVE even when s_axis_valid=0, stalling only at interior positions.
REQ-020 SHALL pulse o_frame_err when an input beat is consumed with s_axis_last not equal to (it is the last interior position); the frame continues without resynchronisation.
REQ-021 SHALL leave s_axis_ready=0 in IDLE, so that an input valid arriving in the same cycle as frame end waits for the next frame.

Reset
REQ-022 SHALL on axi_reset=1 immediately set FSM=IDLE, r=c=0, m_axis_valid=0, m_axis_data=0, m_axis_last=0, m_axis_user=0, s_axis_ready=0, o_frame_err=0.
REQ-023 SHALL discard a partial frame on reset mid-frame, and the next frame SHALL start at (0,0) with user=1.

Structure
REQ-024 SHALL take PAD and the counter width $clog2(max(IMAGE_HEIGHT,IMAGE_WIDTH)) from the shared convolver package, alongside KERNEL_WIDTH and DATA_WIDTH defaults.
REQ-025 SHALL contain one sub-module, pad_position_counter (r/c counters, border flag, first/last flags); the FSM and output register reside in the top.

Verification (IMAGE_HEIGHT=IMAGE_WIDTH=5, KERNEL_WIDTH=3, so 9 interior pixels)
REQ-026 SHALL check that inputs 1..9 with tlast on 9 and ready=1 produce 25 beats: 0,0,0,0,0,0,1,2,3,0,0,4,5,6,0,0,7,8,9,0,0,0,0,0,0; user on beat 0, last on beat 24, err=0.
REQ-027 SHALL check that m_axis_ready toggling 1/0 each cycle produces the same 25-beat sequence, with data stable during every ready=0 cycle.
REQ-028 SHALL check that an input valid gap of 4 cycles before pixel 5 stalls the output at (2,2) and inserts no extra zeros.
REQ-029 SHALL check that tlast on input pixel 7 pulses o_frame_err once and the frame still emits 25 beats.
REQ-030 SHALL check that asserting reset after beat 12 gives all outputs 0 and that the next frame begins with user=1, data 0.
REQ-031 SHALL check that two back-to-back frames yield 50 beats, with IDLE lasting 1 cycle between them and last asserted on beats 24 and 49.

Source files
------------

// File: rtl/zero_pad_framer_pkg.sv
// Shared convolver definitions: default kernel/beat sizes, padding and counter sizing helpers.
package zero_pad_framer_pkg;

    localparam int unsigned DEF_KERNEL_WIDTH = 3;
    localparam int unsigned DEF_DATA_WIDTH   = 32;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } framer_state_t;

    // Border thickness on each side for a square kernel of side k.
    function automatic int unsigned pad_of(input int unsigned k);
        return (k - 1) / 2;
    endfunction

    // Bits needed to hold a row or column index of the padded frame.
    function automatic int unsigned cnt_width(input int unsigned h, input int unsigned w);
        int unsigned m;
        m = (h > w) ? h : w;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/zero_pad_framer_pad_position_counter.sv
// Row/column position of the next padded output beat, with border and frame-edge flags.
module pad_position_counter #(
    parameter int unsigned IMAGE_HEIGHT = 200,
    parameter int unsigned IMAGE_WIDTH  = 200,
    parameter int unsigned PAD          = 1,
    parameter int unsigned CW           = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic step,
    output logic border_c,
    output logic first_c,
    output logic last_c,
    output logic last_interior_c
);

    localparam logic [CW-1:0] R_LAST     = CW'(IMAGE_HEIGHT - 1);
    localparam logic [CW-1:0] C_LAST     = CW'(IMAGE_WIDTH - 1);
    localparam logic [CW-1:0] R_LO       = CW'(PAD);
    localparam logic [CW-1:0] C_LO       = CW'(PAD);
    localparam logic [CW-1:0] R_HI       = CW'(IMAGE_HEIGHT - PAD);
    localparam logic [CW-1:0] C_HI       = CW'(IMAGE_WIDTH - PAD);
    localparam logic [CW-1:0] R_LAST_INT = CW'(IMAGE_HEIGHT - PAD - 1);
    localparam logic [CW-1:0] C_LAST_INT = CW'(IMAGE_WIDTH - PAD - 1);

    logic [CW-1:0] r;
    logic [CW-1:0] c;

    // Raster advance: column first, row on column wrap, both wrap at frame end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r <= '0;
            c <= '0;
        end else if (step) begin
            if (c == C_LAST) begin
                c <= '0;
                r <= (r == R_LAST) ? '0 : r + CW'(1);
            end else begin
                c <= c + CW'(1);
            end
        end
    end

    // Position classification for the beat about to be generated.
    always_comb begin
        border_c        = (r < R_LO) || (r >= R_HI) || (c < C_LO) || (c >= C_HI);
        first_c         = (r == '0) && (c == '0);
        last_c          = (r == R_LAST) && (c == C_LAST);
        last_interior_c = (r == R_LAST_INT) && (c == C_LAST_INT);
    end

endmodule

// File: rtl/zero_pad_framer.sv
// Wraps an unpadded raster stream with a zero border of (KERNEL_WIDTH-1)/2 pixels per side.
module zero_pad_framer
    import zero_pad_framer_pkg::*;
#(
    parameter int unsigned IMAGE_HEIGHT = 200,
    parameter int unsigned IMAGE_WIDTH  = 200,
    parameter int unsigned KERNEL_WIDTH = DEF_KERNEL_WIDTH,
    parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH
) (
    input  logic                  axi_clk,
    input  logic                  axi_reset,
    input  logic                  s_axis_valid,
    output logic                  s_axis_ready,
    input  logic                  s_axis_last,
    input  logic [DATA_WIDTH-1:0] s_axis_data,
    output logic                  m_axis_valid,
    input  logic                  m_axis_ready,
    output logic                  m_axis_last,
    output logic                  m_axis_user,
    output logic [DATA_WIDTH-1:0] m_axis_data,
    output logic                  o_frame_err
);

    localparam int unsigned PAD = pad_of(KERNEL_WIDTH);
    localparam int unsigned CW  = cnt_width(IMAGE_HEIGHT, IMAGE_WIDTH);

    framer_state_t state;
    logic          last_loaded;
    logic          border;
    logic          first_pos;
    logic          last_pos;
    logic          last_interior;
    logic          out_free;
    logic          gen_en;
    logic          load;
    logic          consume;

    pad_position_counter #(
        .IMAGE_HEIGHT (IMAGE_HEIGHT),
        .IMAGE_WIDTH  (IMAGE_WIDTH),
        .PAD          (PAD),
        .CW           (CW)
    ) u_pos (
        .clk             (axi_clk),
        .rst             (axi_reset),
        .step            (load),
        .border_c        (border),
        .first_c         (first_pos),
        .last_c          (last_pos),
        .last_interior_c (last_interior)
    );

    // Load/consume decisions; generation stops once the final beat is queued until it drains.
    always_comb begin
        out_free     = !m_axis_valid || m_axis_ready;
        gen_en       = (state == ST_ACTIVE) && !last_loaded;
        s_axis_ready = gen_en && !border && out_free;
        load         = gen_en && out_free && (border || s_axis_valid);
        consume      = load && !border;
    end

    // Frame FSM, output register and tlast-alignment check.
    always_ff @(posedge axi_clk or posedge axi_reset) begin
        if (axi_reset) begin
            state        <= ST_IDLE;
            last_loaded  <= 1'b0;
            m_axis_valid <= 1'b0;
            m_axis_data  <= '0;
            m_axis_last  <= 1'b0;
            m_axis_user  <= 1'b0;
            o_frame_err  <= 1'b0;
        end else begin
            o_frame_err <= consume && (s_axis_last != last_interior);

            case (state)
                ST_IDLE: begin
                    if (s_axis_valid) begin
                        state <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (m_axis_valid && m_axis_ready && m_axis_last) begin
                        state       <= ST_IDLE;
                        last_loaded <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (load) begin
                m_axis_valid <= 1'b1;
                m_axis_data  <= border ? '0 : s_axis_data;
                m_axis_last  <= last_pos;
                m_axis_user  <= first_pos;
                if (last_pos) begin
                    last_loaded <= 1'b1;
                end
            end else if (m_axis_ready) begin
                m_axis_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_zero_pad_framer.sv
// Directed and randomized checks of zero_pad_framer against a raster-level padding model.
module tb_zero_pad_framer;

    localparam int H   = 5;
    localparam int W   = 5;
    localparam int K   = 3;
    localparam int DW  = 32;
    localparam int NB  = H * W;
    localparam int PAD = (K - 1) / 2;
    localparam int NI  = (H - 2 * PAD) * (W - 2 * PAD);

    logic          clk;
    logic          rst;
    logic          s_valid;
    logic          s_ready;
    logic          s_last;
    logic [DW-1:0] s_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;
    logic          m_user;
    logic [DW-1:0] m_data;
    logic          err;

    zero_pad_framer #(
        .IMAGE_HEIGHT (H),
        .IMAGE_WIDTH  (W),
        .KERNEL_WIDTH (K),
        .DATA_WIDTH   (DW)
    ) dut (
        .axi_clk      (clk),
        .axi_reset    (rst),
        .s_axis_valid (s_valid),
        .s_axis_ready (s_ready),
        .s_axis_last  (s_last),
        .s_axis_data  (s_data),
        .m_axis_valid (m_valid),
        .m_axis_ready (m_ready),
        .m_axis_last  (m_last),
        .m_axis_user  (m_user),
        .m_axis_data  (m_data),
        .o_frame_err  (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    int unsigned exp_data[$];
    bit          exp_last[$];
    bit          exp_user[$];
    int unsigned in_data[$];
    bit          in_last[$];
    int          in_gap[$];
    int          beat_cyc[$];
    int          ready_mode;
    int          err_seen;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        compared++;
        assert (obs === expv)
        else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic clear_all();
        exp_data.delete(); exp_last.delete(); exp_user.delete();
        in_data.delete(); in_last.delete(); in_gap.delete();
    endtask

    // Input pixels: sequential (1,2,..) or random data; tlast on each frame's final pixel.
    task automatic add_pixels(input int n, input bit rnd, input bit rnd_gap);
        for (int k = 0; k < n; k++) begin
            int j;
            j = in_data.size();
            in_data.push_back(rnd ? $urandom : 32'(j + 1));
            in_last.push_back((j % NI) == NI - 1);
            in_gap.push_back(rnd_gap ? int'($urandom_range(0, 2)) : 0);
        end
    endtask

    // Reference: padded raster of one frame, interior filled from inputs starting at base.
    task automatic expect_frame(input int base);
        int k;
        k = base;
        for (int i = 0; i < NB; i++) begin
            int r, c;
            r = i / W;
            c = i % W;
            if (r < PAD || r >= H - PAD || c < PAD || c >= W - PAD) begin
                exp_data.push_back(0);
            end else begin
                exp_data.push_back(in_data[k]);
                k++;
            end
            exp_user.push_back(i == 0);
            exp_last.push_back(i == NB - 1);
        end
    endtask

    function automatic int exp_errs();
        int n;
        n = 0;
        for (int j = 0; j < in_data.size(); j++)
            if (in_last[j] != ((j % NI) == NI - 1)) n++;
        return n;
    endfunction

    task automatic check_zero(input string tag);
        chk({tag, " m_valid"}, 64'(m_valid), 64'(0));
        chk({tag, " m_data"},  64'(m_data),  64'(0));
        chk({tag, " m_last"},  64'(m_last),  64'(0));
        chk({tag, " m_user"},  64'(m_user),  64'(0));
        chk({tag, " s_ready"}, 64'(s_ready), 64'(0));
        chk({tag, " err"},     64'(err),     64'(0));
    endtask

    // Drive inputs and observe outputs cycle by cycle until n_beats (or abort_after) beats pass.
    task automatic run(input string tag, input int n_beats, input int abort_after);
        int pi, ob, gap_left;
        bit pstall, pv, pl, pu;
        logic [DW-1:0] pd;
        pi = 0; ob = 0; pstall = 0; pv = 0; pl = 0; pu = 0; pd = '0;
        gap_left = (in_gap.size() > 0) ? in_gap[0] : 0;
        beat_cyc.delete();
        err_seen = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (ob >= n_beats || (abort_after >= 0 && ob >= abort_after)) break;
            @(negedge clk);
            if (pi < in_data.size() && gap_left == 0) begin
                s_valid = 1'b1;
                s_data  = in_data[pi];
                s_last  = in_last[pi];
            end else begin
                s_valid = 1'b0;
                s_last  = 1'b0;
                if (gap_left > 0) gap_left--;
            end
            case (ready_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = (cyc % 2) == 0;
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (pstall)
                chk($sformatf("%s hold beat%0d", tag, ob),
                    64'({m_valid, m_last, m_user, m_data}), 64'({pv, pl, pu, pd}));
            if (err) err_seen++;
            if (m_valid && m_ready) begin
                chk($sformatf("%s beat%0d data", tag, ob), 64'(m_data), 64'(exp_data[ob]));
                chk($sformatf("%s beat%0d last", tag, ob), 64'(m_last), 64'(exp_last[ob]));
                chk($sformatf("%s beat%0d user", tag, ob), 64'(m_user), 64'(exp_user[ob]));
                beat_cyc.push_back(cyc);
                ob++;
            end
            if (s_valid && s_ready) begin
                pi++;
                gap_left = (pi < in_data.size()) ? in_gap[pi] : 0;
            end
            pstall = m_valid && !m_ready;
            pv = m_valid; pl = m_last; pu = m_user; pd = m_data;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        chk({tag, " beat count"}, 64'(ob), 64'((abort_after >= 0) ? abort_after : n_beats));
    endtask

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0; m_ready = 1'b1;
        ready_mode = 0;
        repeat (2) @(negedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Nominal frame, always ready.
        clear_all(); add_pixels(NI, 0, 0); expect_frame(0);
        ready_mode = 0;
        run("nominal", NB, -1);
        chk("nominal err", 64'(err_seen), 64'(exp_errs()));
        chk("nominal throughput", 64'(beat_cyc[NB-1] - beat_cyc[0]), 64'(NB - 1));

        // Output backpressure toggling every cycle.
        clear_all(); add_pixels(NI, 0, 0); expect_frame(0);
        ready_mode = 1;
        run("toggle", NB, -1);
        chk("toggle err", 64'(err_seen), 64'(exp_errs()));

        // Four idle input cycles before pixel 5 stall the output at (2,2).
        clear_all(); add_pixels(NI, 0, 0); in_gap[4] = 4; expect_frame(0);
        ready_mode = 0;
        run("gap", NB, -1);
        chk("gap err", 64'(err_seen), 64'(exp_errs()));
        chk("gap stall", 64'(beat_cyc[12] - beat_cyc[11]), 64'(5));

        // Early tlast on pixel 7 (final pixel also carries tlast).
        clear_all(); add_pixels(NI, 0, 0); in_last[6] = 1'b1; expect_frame(0);
        run("early_last", NB, -1);
        chk("early_last err", 64'(err_seen), 64'(exp_errs()));
        chk("early_last err once", 64'(err_seen), 64'(1));

        // Reset after beat 12, then a fresh frame.
        clear_all(); add_pixels(NI, 0, 0); expect_frame(0);
        run("pre_reset", NB, 13);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_zero("mid_reset");
        @(negedge clk);
        rst = 1'b0;
        clear_all(); add_pixels(NI, 1, 0); expect_frame(0);
        run("post_reset", NB, -1);
        chk("post_reset err", 64'(err_seen), 64'(exp_errs()));

        // Two frames back to back with continuous input.
        clear_all(); add_pixels(2 * NI, 1, 0); expect_frame(0); expect_frame(NI);
        run("b2b", 2 * NB, -1);
        chk("b2b err", 64'(err_seen), 64'(exp_errs()));
        // frame end handshake, one IDLE cycle, one cycle to load (0,0), then visible
        chk("b2b frame gap", 64'(beat_cyc[NB] - beat_cyc[NB-1]), 64'(3));

        // Random data, random input gaps, random backpressure over three frames.
        clear_all(); add_pixels(3 * NI, 1, 1);
        expect_frame(0); expect_frame(NI); expect_frame(2 * NI);
        ready_mode = 2;
        run("random", 3 * NB, -1);
        chk("random err", 64'(err_seen), 64'(exp_errs()));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
